sipo_deser: RTL and testbench

// - Receive-side counterpart to the team's parallel/serial shift registers.
// - Collects a framed serial bit stream into WIDTH-bit words.
// - Presents each word on a registered parallel output with a valid/ready handshake.
// - Sits at the far end of a serial link, feeding parallel-bus logic such as the pipo stages.
//

---
 rtl/sipo_deser_if.sv | 25 ++
 rtl/sipo_deser.sv | 160 ++++++++++++++++
 tb/tb_sipo_deser.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/sipo_deser_if.sv
// Serial-in / parallel-out link bundle: serial bit side plus parallel word handshake.
// Latency: none, wires only.
// Backpressure: po_ready from the consumer; the serial side has no backpressure.
interface sipo_deser_if #(
  parameter int WIDTH = 4
);
  logic             si;
  logic             si_valid;
  logic             si_start;
  logic [WIDTH-1:0] po;
  logic             po_valid;
  logic             po_ready;

  // Producer of serial bits and consumer of words (e.g. the test harness or link front end)
  modport master (
    output si, si_valid, si_start, po_ready,
    input  po, po_valid
  );

  // The deserializer itself
  modport slave (
    input  si, si_valid, si_start, po_ready,
    output po, po_valid
  );
endinterface

// File: rtl/sipo_deser.sv
// Framed serial-to-parallel deserializer: collects WIDTH serial bits into a registered word.
// Latency: word visible the cycle after the edge sampling its last data bit (or parity bit).
// Backpressure: word held while po_valid & !po_ready; a word completing then is dropped and sets overflow.
// Optional feature macro PARITY_EN: adds one trailing even-parity bit per word and the parity_err pulse.
module sipo_deser #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  sipo_deser_if.slave        bus,
  output logic               busy,
  output logic               overflow,
  input  logic               ovf_clr,
  output logic               frame_err,
  output logic               parity_err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] word;
  logic             done;
  logic             fe_n;
  logic [WIDTH-1:0] po_q;
  logic             po_valid_q;
  logic             overflow_q;
  logic             frame_err_q;

  // Shift register contents after taking in the current serial bit; the
  // direction decides whether the first bit ends up at the MSB or the LSB.
  assign shifted = MSB_FIRST ? {sh[WIDTH-2:0], bus.si} : {bus.si, sh[WIDTH-1:1]};

`ifdef PARITY_EN
  logic par_bad;
  logic parity_err_q;
`endif

  // Framing FSM: a start bit always begins a new word, aborting any partial one
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    word    = sh;
    done    = 1'b0;
    fe_n    = 1'b0;
`ifdef PARITY_EN
    par_bad = 1'b0;
`endif
    if (bus.si_valid) begin
      if (bus.si_start) begin
        fe_n    = (state != IDLE);
        state_n = SHIFT;
        cnt_n   = ONE;
        sh_n    = shifted;
      end else begin
        case (state)
          SHIFT: begin
            sh_n = shifted;
            if (cnt == LAST) begin
`ifdef PARITY_EN
              state_n = PARITY;
              cnt_n   = cnt + ONE;
`else
              done    = 1'b1;
              word    = shifted;
              state_n = IDLE;
              cnt_n   = '0;
`endif
            end else begin
              cnt_n = cnt + ONE;
            end
          end
          PARITY: begin
            done    = 1'b1;
            word    = sh;
            state_n = IDLE;
            cnt_n   = '0;
`ifdef PARITY_EN
            par_bad = ^{sh, bus.si};
`endif
          end
          default: begin
            state_n = state;
          end
        endcase
      end
    end
  end

  // FSM state, bit count and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
    end
  end

  // Output word register: load when the slot is free or being drained this
  // same edge; otherwise the held word wins and the new one is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      po_q        <= '0;
      po_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= fe_n;
      if (done && (!po_valid_q || bus.po_ready)) begin
        po_q       <= word;
        po_valid_q <= 1'b1;
      end else if (po_valid_q && bus.po_ready) begin
        po_valid_q <= 1'b0;
      end
      // A fresh drop takes priority over a clear on the same edge
      if (done && po_valid_q && !bus.po_ready) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr) begin
        overflow_q <= 1'b0;
      end
    end
  end

`ifdef PARITY_EN
  // Parity error pulse, raised alongside completion of the offending word
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= done && par_bad;
    end
  end
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign bus.po       = po_q;
  assign bus.po_valid = po_valid_q;
  assign busy         = (state != IDLE);
  assign overflow     = overflow_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: MSB-first and LSB-first instances driven by the same stream.
// Latency: checks sample 1 time unit after each rising edge.
// Backpressure: po_ready driven directly by the bench to hold, drain and overflow the word register.
module tb_sipo_deser;

`ifdef PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic si, si_valid, si_start, po_ready, ovf_clr;
  logic busy_m, ovf_m, fe_m, pe_m;
  logic busy_l, ovf_l, fe_l, pe_l;
  int   total = 0;
  int   bad   = 0;
  int   fe_cnt;

  always #5 clk = ~clk;

  sipo_deser_if #(.WIDTH(4)) m_if ();
  sipo_deser_if #(.WIDTH(4)) l_if ();

  assign m_if.si       = si;
  assign m_if.si_valid = si_valid;
  assign m_if.si_start = si_start;
  assign m_if.po_ready = po_ready;
  assign l_if.si       = si;
  assign l_if.si_valid = si_valid;
  assign l_if.si_start = si_start;
  assign l_if.po_ready = po_ready;

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bus(m_if), .busy(busy_m), .overflow(ovf_m),
    .ovf_clr(ovf_clr), .frame_err(fe_m), .parity_err(pe_m)
  );

  sipo_deser #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(l_if), .busy(busy_l), .overflow(ovf_l),
    .ovf_clr(ovf_clr), .frame_err(fe_l), .parity_err(pe_l)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic s);
    si       = b;
    si_valid = 1'b1;
    si_start = s;
    @(posedge clk);
    #1;
    si_valid = 1'b0;
    si_start = 1'b0;
    if (fe_m) fe_cnt++;
  endtask

  // Sends w[3] first with start; under parity adds even parity (inverted if pflip).
  // rdy_last / clr_last raise po_ready / ovf_clr for the final bit only.
  task automatic send_word(input logic [3:0] w, input logic rdy_last, input logic clr_last,
                           input logic pflip);
    for (int i = 3; i >= 0; i--) begin
      if (i == 0 && !PAR) begin
        if (rdy_last) po_ready = 1'b1;
        if (clr_last) ovf_clr = 1'b1;
      end
      send_bit(w[i], i == 3);
    end
    if (PAR) begin
      if (rdy_last) po_ready = 1'b1;
      if (clr_last) ovf_clr = 1'b1;
      send_bit((^w) ^ pflip, 1'b0);
    end
    ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; si = 1'b0; si_valid = 1'b0; si_start = 1'b0;
    po_ready = 1'b1; ovf_clr = 1'b0; fe_cnt = 0;
    idle(2);
    check("rst_po", 32'(m_if.po), 32'h0);
    check("rst_vld", 32'(m_if.po_valid), 32'h0);
    check("rst_busy", 32'(busy_m), 32'h0);
    check("rst_ovf", 32'(ovf_m), 32'h0);
    check("rst_fe", 32'(fe_m), 32'h0);
    check("rst_pe", 32'(pe_m), 32'h0);
    rst = 1'b0;
    idle(1);

    // Basic word, back to back, consumer always ready
    send_bit(1'b1, 1'b1);
    check("busy_first", 32'(busy_m), 32'h1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    if (PAR) send_bit(1'b1, 1'b0);
    check("basic_po_msb", 32'(m_if.po), 32'hb);
    check("basic_po_lsb", 32'(l_if.po), 32'hd);
    check("basic_vld", 32'(m_if.po_valid), 32'h1);
    check("basic_busy", 32'(busy_m), 32'h0);
    check("basic_pe", 32'(pe_m), 32'h0);
    idle(1);
    check("basic_vld_drop", 32'(m_if.po_valid), 32'h0);

    // Gaps of 3 idle cycles between bits
    for (int i = 3; i >= 0; i--) begin
      send_bit(i != 2, i == 3);
      if (i > 0 || PAR) begin
        idle(3);
        check("gap_busy", 32'(busy_m), 32'h1);
        check("gap_vld", 32'(m_if.po_valid), 32'h0);
      end
    end
    if (PAR) send_bit(1'b1, 1'b0);
    check("gap_po_msb", 32'(m_if.po), 32'hb);
    check("gap_po_lsb", 32'(l_if.po), 32'hd);
    check("gap_vld", 32'(m_if.po_valid), 32'h1);
    idle(1);

`ifdef PARITY_EN
    // Bad parity: word still delivered, error pulse for one cycle
    send_word(4'b1011, 1'b0, 1'b0, 1'b1);
    check("perr_pulse", 32'(pe_m), 32'h1);
    check("perr_po", 32'(m_if.po), 32'hb);
    check("perr_vld", 32'(m_if.po_valid), 32'h1);
    idle(1);
    check("perr_clear", 32'(pe_m), 32'h0);
`endif

    // Backpressure and overflow
    po_ready = 1'b0;
    send_word(4'b0011, 1'b0, 1'b0, 1'b0);
    check("hold_po_msb", 32'(m_if.po), 32'h3);
    check("hold_po_lsb", 32'(l_if.po), 32'hc);
    send_word(4'b0101, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(ovf_m), 32'h1);
    check("ovf_set_lsb", 32'(ovf_l), 32'h1);
    check("ovf_po_msb", 32'(m_if.po), 32'h3);
    check("ovf_po_lsb", 32'(l_if.po), 32'hc);
    check("ovf_vld", 32'(m_if.po_valid), 32'h1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf_m), 32'h0);
    check("ovf_clr_vld", 32'(m_if.po_valid), 32'h1);
    send_word(4'b1111, 1'b0, 1'b1, 1'b0);
    check("ovf_set_wins", 32'(ovf_m), 32'h1);
    check("ovf_po_keep", 32'(m_if.po), 32'h3);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    // Acceptance on the completing edge: new word loads with no bubble
    send_word(4'b1000, 1'b1, 1'b0, 1'b0);
    check("swap_po_msb", 32'(m_if.po), 32'h8);
    check("swap_po_lsb", 32'(l_if.po), 32'h1);
    check("swap_vld", 32'(m_if.po_valid), 32'h1);
    check("swap_ovf", 32'(ovf_m), 32'h0);
    idle(1);
    check("swap_drain", 32'(m_if.po_valid), 32'h0);

    // Framing error after two bits
    fe_cnt = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_word(4'b0110, 1'b0, 1'b0, 1'b0);
    check("fe_count", 32'(fe_cnt), 32'h1);
    check("fe_po_msb", 32'(m_if.po), 32'h6);
    check("fe_po_lsb", 32'(l_if.po), 32'h6);
    check("fe_vld", 32'(m_if.po_valid), 32'h1);
    check("fe_now", 32'(fe_m), 32'h0);
    idle(1);

    // Start on the last data bit aborts the old word
    fe_cnt = 0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    check("fe_last_pulse", 32'(fe_m), 32'h1);
    check("fe_last_vld", 32'(m_if.po_valid), 32'h0);
    check("fe_last_busy", 32'(busy_m), 32'h1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    if (PAR) send_bit(1'b0, 1'b0);
    check("fe_last_count", 32'(fe_cnt), 32'h1);
    check("fe_last_po_msb", 32'(m_if.po), 32'hc);
    check("fe_last_po_lsb", 32'(l_if.po), 32'h3);
    idle(1);

    // Reset mid-word with a held output
    po_ready = 1'b0;
    send_word(4'b1011, 1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    rst = 1'b1;
    idle(1);
    check("mrst_po", 32'(m_if.po), 32'h0);
    check("mrst_vld", 32'(m_if.po_valid), 32'h0);
    check("mrst_busy", 32'(busy_m), 32'h0);
    check("mrst_ovf", 32'(ovf_m), 32'h0);
    check("mrst_fe", 32'(fe_m), 32'h0);
    check("mrst_pe", 32'(pe_m), 32'h0);
    rst = 1'b0;
    po_ready = 1'b1;
    send_word(4'b0100, 1'b0, 1'b0, 1'b0);
    check("post_rst_msb", 32'(m_if.po), 32'h4);
    check("post_rst_lsb", 32'(l_if.po), 32'h2);
    check("post_rst_busy_l", 32'(busy_l), 32'h0);
    check("post_rst_fe_l", 32'(fe_l), 32'h0);
    check("post_rst_pe_l", 32'(pe_l), 32'h0);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
